// File: rtl/main_control.sv
// Multicycle MIPS main control: Moore FSM with registered control outputs.
// Optional feature macro OVERFLOW_EXC_EN: signed add/sub overflow traps to EXC.
module main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Break,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic [4:0] State
);

  typedef enum logic [4:0] {
    S_FETCH        = 5'd0,
    S_FETCH_WAIT   = 5'd1,
    S_DECODE       = 5'd2,
    S_MEMADDR      = 5'd3,
    S_MEMREAD      = 5'd4,
    S_MEMREAD_WAIT = 5'd5,
    S_MEMWB        = 5'd6,
    S_MEMWRITE     = 5'd7,
    S_RTYPE_EX     = 5'd8,
    S_RTYPE_WB     = 5'd9,
    S_BRANCH       = 5'd10,
    S_JUMP         = 5'd11,
    S_ADDI_EX      = 5'd12,
    S_ADDI_WB      = 5'd13,
    S_HALT         = 5'd14,
    S_EXC          = 5'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   ovf_trap;

  // Control word for a state; opcode only picks beq vs bne for BRANCH and is
  // sampled when the state is entered, so outputs stay a pure function of State.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      S_FETCH_WAIT: c.ir_write = 1'b1;
      S_DECODE:     c.alu_src_b = 2'b11;
      S_MEMADDR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMREAD, S_MEMREAD_WAIT: c.i_or_d = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_RTYPE_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b010;
      end
      S_RTYPE_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a        = 1'b1;
        c.alu_op           = 3'b001;
        c.pc_source        = 2'b01;
        c.pc_write_cond    = (op == 6'h04);
        c.pc_write_cond_ne = (op == 6'h05);
      end
      S_JUMP: begin
        c.pc_source = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_ADDI_WB: c.reg_write = 1'b1;
      S_EXC: begin
        c.pc_source = 2'b11;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

`ifdef OVERFLOW_EXC_EN
  logic unused_inputs;
  assign unused_inputs = Zero;
  assign ovf_trap      = Overflow;
`else
  // Overflow is ignored, so EXC has no entry arc in this build.
  logic unused_inputs;
  assign unused_inputs = ^{Zero, Overflow, Funct};
  assign ovf_trap      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          6'h00:        state_d = Break ? S_HALT : S_RTYPE_EX;
          6'h23, 6'h2B: state_d = S_MEMADDR;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          6'h08:        state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADDR:      state_d = (Opcode == 6'h23) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:      state_d = S_MEMREAD_WAIT;
      S_MEMREAD_WAIT: state_d = S_MEMWB;
`ifdef OVERFLOW_EXC_EN
      // Only signed ADD/SUB trap; ADDU/SUBU wrap silently.
      S_RTYPE_EX: state_d = (ovf_trap && (Funct == 6'h20 || Funct == 6'h22))
                            ? S_EXC : S_RTYPE_WB;
`else
      S_RTYPE_EX: state_d = S_RTYPE_WB;
`endif
      S_ADDI_EX:  state_d = ovf_trap ? S_EXC : S_ADDI_WB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_of(state_d, Opcode);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_of(S_FETCH, Opcode);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign PCWrite       = ctrl_q.pc_write;
  assign PCWriteCond   = ctrl_q.pc_write_cond;
  assign PCWriteCondNe = ctrl_q.pc_write_cond_ne;
  assign IorD          = ctrl_q.i_or_d;
  assign MemWrite      = ctrl_q.mem_write;
  assign IRWrite       = ctrl_q.ir_write;
  assign RegDst        = ctrl_q.reg_dst;
  assign MemtoReg      = ctrl_q.mem_to_reg;
  assign RegWrite      = ctrl_q.reg_write;
  assign ALUSrcA       = ctrl_q.alu_src_a;
  assign ALUSrcB       = ctrl_q.alu_src_b;
  assign PCSource      = ctrl_q.pc_source;
  assign ALUOp         = ctrl_q.alu_op;
  assign State         = state_q;

endmodule

// File: tb/tb_main_control.sv
// Directed bench for main_control; expected state codes and controls are hand-derived.
module tb_main_control;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Break;
  logic       Zero;
  logic       Overflow;
  logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [4:0] State;

  int n_tests;
  int n_fail;

  main_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Break(Break),
    .Zero(Zero), .Overflow(Overflow), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCWriteCondNe(PCWriteCondNe), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .State(State)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // advance one cycle and check the state code
  task automatic go(input string tag, input logic [4:0] exp_state);
    step();
    check_eq(tag, {27'd0, State}, {27'd0, exp_state});
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic brk, input logic ovf);
    Opcode   = op;
    Funct    = fn;
    Break    = brk;
    Overflow = ovf;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    Zero    = 1'b0;
    set_instr(6'h00, 6'h20, 1'b0, 1'b0);

    // reset for two cycles
    step();
    step();
    check_eq("rst_state", {27'd0, State}, 32'd0);
    check_eq("rst_pcwrite", {31'd0, PCWrite}, 32'd1);
    check_eq("rst_alusrcb", {30'd0, ALUSrcB}, 32'd1);
    check_eq("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    reset = 1'b0;

    // ADD: 0,1,2,8,9,0
    go("add_s1", 5'd1);
    check_eq("add_irwrite", {31'd0, IRWrite}, 32'd1);
    go("add_s2", 5'd2);
    check_eq("dec_alusrcb", {30'd0, ALUSrcB}, 32'd3);
    check_eq("dec_regwrite", {31'd0, RegWrite}, 32'd0);
    go("add_s8", 5'd8);
    check_eq("add_aluop", {29'd0, ALUOp}, 32'd2);
    check_eq("add_alusrca", {31'd0, ALUSrcA}, 32'd1);
    check_eq("add_rw_s8", {31'd0, RegWrite}, 32'd0);
    go("add_s9", 5'd9);
    check_eq("add_rw_s9", {31'd0, RegWrite}, 32'd1);
    check_eq("add_regdst", {31'd0, RegDst}, 32'd1);
    check_eq("add_aluop_s9", {29'd0, ALUOp}, 32'd0);
    go("add_s0", 5'd0);
    check_eq("add_rw_s0", {31'd0, RegWrite}, 32'd0);

    // LW: 0,1,2,3,4,5,6,0
    set_instr(6'h23, 6'h00, 1'b0, 1'b0);
    go("lw_s1", 5'd1);
    go("lw_s2", 5'd2);
    go("lw_s3", 5'd3);
    check_eq("lw_alusrcb", {30'd0, ALUSrcB}, 32'd2);
    go("lw_s4", 5'd4);
    check_eq("lw_iord_s4", {31'd0, IorD}, 32'd1);
    go("lw_s5", 5'd5);
    check_eq("lw_iord_s5", {31'd0, IorD}, 32'd1);
    go("lw_s6", 5'd6);
    check_eq("lw_memtoreg", {31'd0, MemtoReg}, 32'd1);
    check_eq("lw_regwrite", {31'd0, RegWrite}, 32'd1);
    check_eq("lw_iord_s6", {31'd0, IorD}, 32'd0);
    go("lw_s0", 5'd0);

    // BNE with Zero=0
    set_instr(6'h05, 6'h00, 1'b0, 1'b0);
    go("bne_s1", 5'd1);
    go("bne_s2", 5'd2);
    go("bne_s10", 5'd10);
    check_eq("bne_condne", {31'd0, PCWriteCondNe}, 32'd1);
    check_eq("bne_cond", {31'd0, PCWriteCond}, 32'd0);
    check_eq("bne_pcsrc", {30'd0, PCSource}, 32'd1);
    check_eq("bne_aluop", {29'd0, ALUOp}, 32'd1);
    go("bne_s0", 5'd0);

    // BEQ
    set_instr(6'h04, 6'h00, 1'b0, 1'b0);
    go("beq_s1", 5'd1);
    go("beq_s2", 5'd2);
    go("beq_s10", 5'd10);
    check_eq("beq_cond", {31'd0, PCWriteCond}, 32'd1);
    check_eq("beq_condne", {31'd0, PCWriteCondNe}, 32'd0);
    go("beq_s0", 5'd0);

    // J
    set_instr(6'h02, 6'h00, 1'b0, 1'b0);
    go("j_s1", 5'd1);
    go("j_s2", 5'd2);
    go("j_s11", 5'd11);
    check_eq("j_pcsrc", {30'd0, PCSource}, 32'd2);
    check_eq("j_pcwrite", {31'd0, PCWrite}, 32'd1);
    go("j_s0", 5'd0);

    // unknown opcode acts as NOP
    set_instr(6'h3F, 6'h00, 1'b0, 1'b0);
    go("nop_s1", 5'd1);
    go("nop_s2", 5'd2);
    go("nop_s0", 5'd0);

    // ADDU with overflow never traps
    set_instr(6'h00, 6'h21, 1'b0, 1'b1);
    go("addu_s1", 5'd1);
    go("addu_s2", 5'd2);
    go("addu_s8", 5'd8);
    go("addu_s9", 5'd9);
    go("addu_s0", 5'd0);

    // ADDI with overflow
    set_instr(6'h08, 6'h00, 1'b0, 1'b1);
    go("addi_s1", 5'd1);
    go("addi_s2", 5'd2);
    go("addi_s12", 5'd12);
    check_eq("addi_alusrcb", {30'd0, ALUSrcB}, 32'd2);
`ifdef OVERFLOW_EXC_EN
    go("addi_s15", 5'd15);
    check_eq("exc_pcsrc", {30'd0, PCSource}, 32'd3);
    check_eq("exc_pcwrite", {31'd0, PCWrite}, 32'd1);
    check_eq("exc_regwrite", {31'd0, RegWrite}, 32'd0);
`else
    go("addi_s13", 5'd13);
    check_eq("addi_regwrite", {31'd0, RegWrite}, 32'd1);
    check_eq("addi_regdst", {31'd0, RegDst}, 32'd0);
`endif
    go("addi_s0", 5'd0);

    // signed SUB with overflow
    set_instr(6'h00, 6'h22, 1'b0, 1'b1);
    go("sub_s1", 5'd1);
    go("sub_s2", 5'd2);
    go("sub_s8", 5'd8);
`ifdef OVERFLOW_EXC_EN
    go("sub_s15", 5'd15);
    check_eq("sub_regwrite", {31'd0, RegWrite}, 32'd0);
`else
    go("sub_s9", 5'd9);
    check_eq("sub_regwrite", {31'd0, RegWrite}, 32'd1);
`endif
    go("sub_s0", 5'd0);

    // BREAK -> HALT, held, then reset
    set_instr(6'h00, 6'h0D, 1'b1, 1'b0);
    go("brk_s1", 5'd1);
    go("brk_s2", 5'd2);
    go("brk_s14", 5'd14);
    check_eq("halt_pcwrite", {31'd0, PCWrite}, 32'd0);
    for (int i = 0; i < 11; i++) go("halt_hold", 5'd14);
    reset = 1'b1;
    go("halt_rst", 5'd0);
    reset = 1'b0;
    Break = 1'b0;

    // SW interrupted by reset in MEMWRITE
    set_instr(6'h2B, 6'h00, 1'b0, 1'b0);
    go("sw_s1", 5'd1);
    go("sw_s2", 5'd2);
    go("sw_s3", 5'd3);
    go("sw_s7", 5'd7);
    check_eq("sw_memwrite", {31'd0, MemWrite}, 32'd1);
    check_eq("sw_iord", {31'd0, IorD}, 32'd1);
    reset = 1'b1;
    go("sw_rst", 5'd0);
    check_eq("sw_rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check_eq("sw_rst_pcwrite", {31'd0, PCWrite}, 32'd1);
    reset = 1'b0;
    go("sw_refetch", 5'd1);
    check_eq("sw_refetch_memwrite", {31'd0, MemWrite}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/main_control.md
MAIN_CONTROL -- requirements
Module: main_control

Interface
REQ-001 The block SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-003 The block SHALL have port: Opcode  input  6  instruction[31:26], sampled from the instruction register.
REQ-004 The block SHALL have port: Funct  input  6  instruction[5:0].
REQ-005 The block SHALL have port: Break  input  1  break flag from the ALU function decoder.
REQ-006 The block SHALL have port: Zero  input  1  ALU zero flag.
REQ-007 The block SHALL have port: Overflow  input  1  ALU signed overflow.
REQ-008 The block SHALL have outputs, all 1 bit: PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA.
REQ-009 The block SHALL have port: ALUSrcB  output  2  selects 00=B, 01=const 4, 10=signext imm, 11=signext imm<<2.
REQ-010 The block SHALL have port: PCSource  output  2  selects 00=ALU, 01=ALUOut, 10=jump target, 11=exception vector.
REQ-011 The block SHALL have port: ALUOp  output  3  encodes 000=add, 001=sub, 010=use Funct; no other value driven.
REQ-012 The block SHALL have port: State  output  5  current state code, for debug.

Function
REQ-013 The block SHALL be a Moore FSM: every output is a function of State only, registered state, no output depends combinationally on inputs.
REQ-014 The block SHALL drive all outputs to 0 (ALUOp=000) in any state that does not explicitly assert them.
REQ-015 The block SHALL use states FETCH(0), FETCH_WAIT(1), DECODE(2), MEMADDR(3), MEMREAD(4), MEMREAD_WAIT(5), MEMWB(6), MEMWRITE(7), RTYPE_EX(8), RTYPE_WB(9), BRANCH(10), JUMP(11), ADDI_EX(12), ADDI_WB(13), HALT(14), EXC(15).
REQ-016 FETCH SHALL assert: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00, PCWrite=1; next state is FETCH_WAIT.
REQ-017 FETCH_WAIT SHALL assert IRWrite=1 and go to DECODE; this covers the one-cycle memory read latency.
REQ-018 DECODE SHALL assert ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut).
REQ-019 DECODE SHALL branch on Opcode: 0x00 to RTYPE_EX (or HALT if Break=1); 0x23 or 0x2B to MEMADDR; 0x04 or 0x05 to BRANCH; 0x02 to JUMP; 0x08 to ADDI_EX; any other value to FETCH (treated as NOP).
REQ-020 MEMADDR SHALL assert ALUSrcA=1, ALUSrcB=10, ALUOp=000, then go to MEMREAD if Opcode=0x23, else to MEMWRITE.
REQ-021 MEMREAD SHALL assert IorD=1 and go to MEMREAD_WAIT; MEMREAD_WAIT SHALL assert IorD=1 and go to MEMWB.
REQ-022 MEMWB SHALL assert RegDst=0, MemtoReg=1, RegWrite=1; next state is FETCH.
REQ-023 MEMWRITE SHALL assert IorD=1, MemWrite=1; next state is FETCH.
REQ-024 RTYPE_EX SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=010; RTYPE_WB SHALL assert RegDst=1, MemtoReg=0, RegWrite=1; next state is FETCH.
REQ-025 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, plus PCWriteCond (opcode 0x04) or PCWriteCondNe (opcode 0x05); next state is FETCH.
REQ-026 JUMP SHALL assert PCSource=10, PCWrite=1; next state is FETCH.
REQ-027 ADDI_EX SHALL assert ALUSrcA=1, ALUSrcB=10, ALUOp=000; ADDI_WB SHALL assert RegDst=0, MemtoReg=0, RegWrite=1; next state is FETCH.
REQ-028 HALT SHALL drive all outputs to 0 and remain in HALT until reset.
REQ-029 EXC SHALL assert PCSource=11, PCWrite=1; next state is FETCH.

Reset
REQ-030 When reset=1 at a clock edge, the block SHALL set State=FETCH, regardless of the current state, including mid-instruction, HALT and EXC.
REQ-031 In the cycle after reset deasserts, the block SHALL perform a normal FETCH; no partial write from the aborted instruction may occur after reset.

Configuration
REQ-032 With OVERFLOW_EXC_EN defined, RTYPE_EX SHALL go to EXC if Overflow=1 and Funct is 0x20 or 0x22, and ADDI_EX SHALL go to EXC if Overflow=1; in both cases RegWrite is never asserted.
REQ-033 With OVERFLOW_EXC_EN undefined, Overflow SHALL be ignored and EXC SHALL be unreachable; the state encoding is unchanged.
REQ-034 In both configurations, ADDU (0x21) and SUBU (0x23) SHALL never trap.

Verification
REQ-035 The bench SHALL check: reset for 2 cycles, then Opcode=0x00, Funct=0x20 -> State sequence 0,1,2,8,9,0; RegWrite=1 only in state 9; ALUOp=010 in state 8.
REQ-036 The bench SHALL check: Opcode=0x23 -> State sequence 0,1,2,3,4,5,6,0; MemtoReg=1 and RegWrite=1 in state 6; IorD=1 in states 4 and 5.
REQ-037 The bench SHALL check: Opcode=0x05 with Zero=0 in BRANCH -> PCWriteCondNe=1, PCWriteCond=0, PCSource=01, ALUOp=001.
REQ-038 The bench SHALL check: Opcode=0x00 with Break=1 at DECODE -> State=14, held for 10+ cycles; then reset=1 -> State=0 on the next edge.
REQ-039 The bench SHALL check, with OVERFLOW_EXC_EN defined: Opcode=0x08 with Overflow=1 in ADDI_EX -> State 12,15,0; PCSource=11 and PCWrite=1 in state 15; no RegWrite.
REQ-040 The bench SHALL check: reset asserted in state 7 -> MemWrite=0 on the next cycle and State=0.
